// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer driving an 8-bit ALU from a small register file
// Optional sticky carry/overflow flags: define ALU_SEQ_STICKY_FLAGS_EN.
module alu_sequencer #(
    parameter int NREG     = 4,
    parameter int ALU_WAIT = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [AW-1:0] req_ra,
    input  logic [AW-1:0] req_rb,
    input  logic [AW-1:0] req_rd,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_s,
    input  logic [7:0]    alu_r,
    input  logic          alu_c,
    input  logic          alu_v,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic          rsp_c,
    output logic          rsp_v,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    output logic          sticky_c,
    output logic          sticky_v,
    input  logic          sticky_clr,
`endif
    output logic          rsp_err
);

    localparam int CW = $clog2(ALU_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      rf_q [NREG];
    logic [7:0]      rf_d [NREG];
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [3:0]      alu_s_q, alu_s_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_c_q, rsp_c_d;
    logic            rsp_v_q, rsp_v_d;
    logic            rsp_err_q, rsp_err_d;
    logic            op_legal;
    logic            capture;

    // Legal opcodes form the contiguous range 0111..1110.
    assign op_legal = (req_op >= 4'b0111) && (req_op <= 4'b1110);

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_c_d    = rsp_c_q;
        rsp_v_d    = rsp_v_q;
        rsp_err_d  = rsp_err_q;
        capture    = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (ld_en) begin
            rf_d[ld_addr] = ld_data;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (op_legal) begin
                        alu_a_d = rf_q[req_ra];
                        alu_b_d = rf_q[req_rb];
                        alu_s_d = req_op;
                        rd_d    = req_rd;
                        cnt_d   = CW'(ALU_WAIT);
                        state_d = EXEC;
                    end else begin
                        rsp_data_d = 8'h00;
                        rsp_c_d    = 1'b0;
                        rsp_v_d    = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    capture    = 1'b1;
                    rsp_data_d = alu_r;
                    rsp_c_d    = alu_c;
                    rsp_v_d    = alu_v;
                    rsp_err_d  = 1'b0;
                    // Writeback overrides a same-edge load to the same address.
                    rf_d[rd_q] = alu_r;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            alu_s_q    <= 4'b1000;
            rd_q       <= '0;
            cnt_q      <= '0;
            rsp_data_q <= 8'h00;
            rsp_c_q    <= 1'b0;
            rsp_v_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_c_q    <= rsp_c_d;
            rsp_v_q    <= rsp_v_d;
            rsp_err_q  <= rsp_err_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic sticky_c_q, sticky_c_d;
    logic sticky_v_q, sticky_v_d;

    // A flag raised by a same-edge capture survives a clear request.
    always_comb begin
        sticky_c_d = sticky_c_q & ~sticky_clr;
        sticky_v_d = sticky_v_q & ~sticky_clr;
        if (capture) begin
            sticky_c_d = sticky_c_d | alu_c;
            sticky_v_d = sticky_v_d | alu_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
        end else begin
            sticky_c_q <= sticky_c_d;
            sticky_v_q <= sticky_v_d;
        end
    end

    assign sticky_c = sticky_c_q;
    assign sticky_v = sticky_v_q;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [1:0] req_ra;
    logic [1:0] req_rb;
    logic [1:0] req_rd;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_s;
    logic [7:0] alu_r;
    logic       alu_c;
    logic       alu_v;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_c;
    logic       rsp_v;
    logic       rsp_err;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic       sticky_c;
    logic       sticky_v;
    logic       sticky_clr;
`endif

    int n_cmp;
    int n_bad;

    alu_sequencer #(.NREG(4), .ALU_WAIT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_rd    (req_rd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_r     (alu_r),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        .sticky_c  (sticky_c),
        .sticky_v  (sticky_v),
        .sticky_clr(sticky_clr),
`endif
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: c is carry (add) or borrow (sub), v is signed overflow.
    always_comb begin
        logic [8:0] wide;
        wide  = 9'h000;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_s)
            4'b1001: begin
                wide  = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c = wide[8];
                alu_v = (alu_a[7] != alu_b[7]) && (wide[7] != alu_a[7]);
            end
            4'b1010: begin
                wide  = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = wide[8];
                alu_v = (alu_a[7] == alu_b[7]) && (wide[7] != alu_a[7]);
            end
            4'b1011: wide = {1'b0, alu_a ^ alu_b};
            4'b1100: wide = {1'b0, ~alu_a};
            4'b1101: wide = {1'b0, alu_a | alu_b};
            4'b1110: wide = {1'b0, alu_a & alu_b};
            default: wide = {1'b0, alu_a};
        endcase
        alu_r = wide[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // One complete legal operation with the default one-cycle ALU wait.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [1:0] rd,
                         input logic [7:0] exp_data, input logic exp_c, input logic exp_v);
        req_valid = 1'b1;
        req_op    = op;
        req_ra    = ra;
        req_rb    = rb;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
        check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_cv"}, 32'({rsp_c, rsp_v, rsp_err}), 32'({exp_c, exp_v, 1'b0}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_idle"}, 32'({req_ready, rsp_valid}), 32'b10);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        ld_en     = 1'b0;
        ld_addr   = 2'd0;
        ld_data   = 8'h00;
        req_valid = 1'b0;
        req_op    = 4'b1000;
        req_ra    = 2'd0;
        req_rb    = 2'd0;
        req_rd    = 2'd0;
        rsp_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_s", 32'(alu_s), 32'h8);
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'h0000);
        check("rst_rsp", 32'({rsp_data, rsp_c, rsp_v, rsp_err}), 32'd0);

        load(2'd0, 8'h95);
        load(2'd1, 8'h35);
        do_op("and", 4'b1110, 2'd0, 2'd1, 2'd2, 8'h15, 1'b0, 1'b0);
        do_op("xfer_r2", 4'b1000, 2'd2, 2'd0, 2'd3, 8'h15, 1'b0, 1'b0);

        load(2'd0, 8'h0F);
        load(2'd1, 8'h03);
        do_op("add", 4'b1010, 2'd0, 2'd1, 2'd3, 8'h12, 1'b0, 1'b0);
        do_op("add_carry", 4'b1010, 2'd2, 2'd2, 2'd3, 8'h2A, 1'b0, 1'b0);

        // Response back-pressure with a new request waiting.
        req_valid = 1'b1;
        req_op    = 4'b1001;
        req_ra    = 2'd0;
        req_rb    = 2'd1;
        req_rd    = 2'd3;
        tick();
        req_op = 4'b1101;
        req_rd = 2'd2;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_data", 32'({rsp_data, rsp_c, rsp_v}), 32'({8'h0C, 2'b00}));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_idle", 32'({req_ready, rsp_valid}), 32'b10);
        tick();
        req_valid = 1'b0;
        check("bp_accept", 32'(req_ready), 32'd0);
        tick();
        check("bp_or", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'h0F}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Illegal opcode.
        req_valid = 1'b1;
        req_op    = 4'b0011;
        req_ra    = 2'd0;
        req_rb    = 2'd1;
        req_rd    = 2'd0;
        tick();
        req_valid = 1'b0;
        check("ill_rsp", 32'({rsp_valid, rsp_err, rsp_data, rsp_c, rsp_v}), 32'({2'b11, 8'h00, 2'b00}));
        check("ill_alu_s", 32'(alu_s), 32'hD);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_op("ill_r0", 4'b1000, 2'd0, 2'd0, 2'd3, 8'h0F, 1'b0, 1'b0);
        do_op("ill_r2", 4'b0111, 2'd2, 2'd0, 2'd3, 8'h0F, 1'b0, 1'b0);

        // Load colliding with the capture edge: writeback wins.
        load(2'd0, 8'h95);
        load(2'd1, 8'h35);
        req_valid = 1'b1;
        req_op    = 4'b1110;
        req_ra    = 2'd0;
        req_rb    = 2'd1;
        req_rd    = 2'd2;
        tick();
        req_valid = 1'b0;
        ld_en     = 1'b1;
        ld_addr   = 2'd2;
        ld_data   = 8'hAA;
        tick();
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_op("coll_same", 4'b1000, 2'd2, 2'd0, 2'd3, 8'h15, 1'b0, 1'b0);

        req_valid = 1'b1;
        req_rd    = 2'd2;
        req_op    = 4'b1110;
        req_ra    = 2'd0;
        req_rb    = 2'd1;
        tick();
        req_valid = 1'b0;
        tick();
        load(2'd2, 8'hAA);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_op("coll_late", 4'b1000, 2'd2, 2'd0, 2'd3, 8'hAA, 1'b0, 1'b0);

        // Load and accept on the same edge: operand sees the old value.
        ld_en     = 1'b1;
        ld_addr   = 2'd0;
        ld_data   = 8'h77;
        req_valid = 1'b1;
        req_op    = 4'b1000;
        req_ra    = 2'd0;
        req_rd    = 2'd3;
        tick();
        ld_en     = 1'b0;
        req_valid = 1'b0;
        tick();
        check("rbw_data", 32'(rsp_data), 32'h95);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        do_op("rbw_new", 4'b1000, 2'd0, 2'd0, 2'd3, 8'h77, 1'b0, 1'b0);

        // Subtract with borrow and signed overflow: 0x00 - 0x80.
        load(2'd1, 8'h80);
        load(2'd0, 8'h00);
        do_op("sub_bv", 4'b1001, 2'd0, 2'd1, 2'd2, 8'h80, 1'b1, 1'b1);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
        check("sticky_set", 32'({sticky_c, sticky_v}), 32'b11);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("sticky_clr", 32'({sticky_c, sticky_v}), 32'b00);
        load(2'd0, 8'h80);
        load(2'd1, 8'h01);
        do_op("sub_v", 4'b1001, 2'd0, 2'd1, 2'd2, 8'h7F, 1'b0, 1'b1);
        check("sticky_v", 32'({sticky_c, sticky_v}), 32'b01);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check("sticky_v_clr", 32'({sticky_c, sticky_v}), 32'b00);
`endif

        // Reset during EXEC discards the operation.
        req_valid = 1'b1;
        req_op    = 4'b1010;
        req_ra    = 2'd0;
        req_rb    = 2'd1;
        req_rd    = 2'd3;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        check("exrst_state", 32'({req_ready, rsp_valid}), 32'b10);
        check("exrst_alu", 32'({alu_a, alu_b, alu_s}), 32'({8'h00, 8'h00, 4'h8}));
        tick();
        check("exrst_norsp", 32'(rsp_valid), 32'd0);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        check("exrst_sticky", 32'({sticky_c, sticky_v}), 32'b00);
`endif
        for (int i = 0; i < 4; i++) begin
            do_op("exrst_rf", 4'b1000, 2'(i), 2'd0, 2'(i), 8'h00, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
